// File: rtl/inert_seq.sv
// ----------------------------------------------------------------------------
// inert_seq
//   Owns the SPI main-side transaction port to the iNEMO inertial sensor.
//   After reset it waits WAIT_CYC clocks for sensor power-up, issues four
//   configuration writes, then services each data-ready interrupt with a
//   ten-byte burst read. The assembled gyro-rate and acceleration words are
//   published together with a one-cycle vld pulse.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   INT        sensor data-ready (asynchronous level, synchronized inside)
//   done       one-cycle pulse: current SPI transaction complete
//   resp       SPI read data, resp[7:0] valid while done is high
//   wrt        one-cycle pulse starting an SPI transaction
//   cmd        SPI command word, stable from wrt through the matching done
//   ptch_rt    pitch rate  (signed)
//   roll_rt    roll rate   (signed)
//   yaw_rt     yaw rate    (signed)
//   ax, ay     accelerations (signed)
//   vld        one-cycle pulse: all five data outputs updated this cycle
//   init_done  sticky flag: all configuration writes have completed
// ----------------------------------------------------------------------------
module inert_seq #(
    parameter int unsigned WAIT_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INT,
    input  logic               done,
    input  logic [15:0]        resp,
    output logic               wrt,
    output logic [15:0]        cmd,
    output logic signed [15:0] ptch_rt,
    output logic signed [15:0] roll_rt,
    output logic signed [15:0] yaw_rt,
    output logic signed [15:0] ax,
    output logic signed [15:0] ay,
    output logic               vld,
    output logic               init_done
);

    typedef enum logic [2:0] {
        INIT_WAIT,
        CFG,
        WAIT_INT,
        RD,
        PUBLISH
    } state_t;

    localparam logic [15:0] LP_WAIT_LAST = 16'(WAIT_CYC - 1);

    function automatic logic [15:0] f_cfg_cmd(input logic [1:0] idx);
        logic [15:0] c;
        case (idx)
            2'd0:    c = 16'h0D02;  // data-ready routed to INT
            2'd1:    c = 16'h1053;  // accel ODR / range
            2'd2:    c = 16'h1150;  // gyro ODR / range
            default: c = 16'h1460;  // rounding
        endcase
        return c;
    endfunction

    function automatic logic [15:0] f_rd_cmd(input logic [3:0] idx);
        return {8'hA2 + {4'h0, idx}, 8'h00};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [15:0]        r_cnt;
    logic [3:0]         r_idx;
    logic               r_int_meta;
    logic               r_int_sync;
    logic               r_wrt;
    logic [15:0]        r_cmd;
    logic [7:0]         r_stage [9];
    logic signed [15:0] r_ptch, r_roll, r_yaw, r_ax, r_ay;
    logic               r_vld;
    logic               r_init_done;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [15:0]        w_cnt_nxt;
    logic [3:0]         w_idx_nxt;
    logic               w_wrt_nxt;
    logic [15:0]        w_cmd_nxt;
    logic [7:0]         w_stage_nxt [9];
    logic signed [15:0] w_ptch_nxt, w_roll_nxt, w_yaw_nxt, w_ax_nxt, w_ay_nxt;
    logic               w_vld_nxt;
    logic               w_init_done_nxt;
    logic [3:0]         w_idx_inc;
    logic               w_unused;

    // Only the low response byte carries read data.
    assign w_unused  = ^resp[15:8];
    assign w_idx_inc = r_idx + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_meta <= 1'b0;
            r_int_sync <= 1'b0;
        end else begin
            r_int_meta <= INT;
            r_int_sync <= r_int_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT_WAIT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_wrt       <= 1'b0;
            r_cmd       <= '0;
            r_stage     <= '{default: '0};
            r_ptch      <= '0;
            r_roll      <= '0;
            r_yaw       <= '0;
            r_ax        <= '0;
            r_ay        <= '0;
            r_vld       <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_wrt       <= w_wrt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_stage     <= w_stage_nxt;
            r_ptch      <= w_ptch_nxt;
            r_roll      <= w_roll_nxt;
            r_yaw       <= w_yaw_nxt;
            r_ax        <= w_ax_nxt;
            r_ay        <= w_ay_nxt;
            r_vld       <= w_vld_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    // Each transaction is launched on the transition that ends the previous
    // one (or enters the state), so wrt lands the cycle after done.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_wrt_nxt       = 1'b0;
        w_cmd_nxt       = r_cmd;
        w_stage_nxt     = r_stage;
        w_ptch_nxt      = r_ptch;
        w_roll_nxt      = r_roll;
        w_yaw_nxt       = r_yaw;
        w_ax_nxt        = r_ax;
        w_ay_nxt        = r_ay;
        w_vld_nxt       = 1'b0;
        w_init_done_nxt = r_init_done;

        case (r_state)
            INIT_WAIT: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (r_cnt == LP_WAIT_LAST) begin
                    w_state_nxt = CFG;
                    w_idx_nxt   = '0;
                    w_wrt_nxt   = 1'b1;
                    w_cmd_nxt   = f_cfg_cmd(2'd0);
                end
            end

            CFG: begin
                if (done) begin
                    if (r_idx == 4'd3) begin
                        w_init_done_nxt = 1'b1;
                        w_state_nxt     = WAIT_INT;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_wrt_nxt = 1'b1;
                        w_cmd_nxt = f_cfg_cmd(w_idx_inc[1:0]);
                    end
                end
            end

            WAIT_INT: begin
                if (r_int_sync) begin
                    w_state_nxt = RD;
                    w_idx_nxt   = '0;
                    w_wrt_nxt   = 1'b1;
                    w_cmd_nxt   = f_rd_cmd(4'd0);
                end
            end

            RD: begin
                if (done) begin
                    if (r_idx == 4'd9) begin
                        // Last byte goes straight to the outputs so vld can
                        // follow the final done by one clock; PUBLISH is the
                        // cycle in which vld is high.
                        w_ptch_nxt  = {r_stage[1], r_stage[0]};
                        w_roll_nxt  = {r_stage[3], r_stage[2]};
                        w_yaw_nxt   = {r_stage[5], r_stage[4]};
                        w_ax_nxt    = {r_stage[7], r_stage[6]};
                        w_ay_nxt    = {resp[7:0], r_stage[8]};
                        w_vld_nxt   = 1'b1;
                        w_state_nxt = PUBLISH;
                    end else begin
                        w_stage_nxt[r_idx] = resp[7:0];
                        w_idx_nxt          = w_idx_inc;
                        w_wrt_nxt          = 1'b1;
                        w_cmd_nxt          = f_rd_cmd(w_idx_inc);
                    end
                end
            end

            PUBLISH: begin
                w_state_nxt = WAIT_INT;
            end

            default: begin
                w_state_nxt = INIT_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign wrt       = r_wrt;
    assign cmd       = r_cmd;
    assign ptch_rt   = r_ptch;
    assign roll_rt   = r_roll;
    assign yaw_rt    = r_yaw;
    assign ax        = r_ax;
    assign ay        = r_ay;
    assign vld       = r_vld;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_inert_seq.sv
// ----------------------------------------------------------------------------
// tb_inert_seq
//   Directed bench for inert_seq: an SPI responder returns done LAT clocks
//   after each wrt, a monitor logs wrt/cmd/done/vld activity, and the main
//   sequence drives INT/reset and compares against hand-computed values.
// ----------------------------------------------------------------------------
module tb_inert_seq;

    localparam int unsigned WAIT_CYC = 16;
    localparam int          LAT      = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               INT;
    logic               done;
    logic [15:0]        resp;
    logic               wrt;
    logic [15:0]        cmd;
    logic signed [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;
    logic               vld;
    logic               init_done;

    logic        m_done = 1'b0;
    logic        t_done = 1'b0;
    logic [15:0] m_resp = '0;
    logic [15:0] t_resp = '0;
    assign done = m_done | t_done;
    assign resp = t_done ? t_resp : m_resp;

    inert_seq #(.WAIT_CYC(WAIT_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .INT       (INT),
        .done      (done),
        .resp      (resp),
        .wrt       (wrt),
        .cmd       (cmd),
        .ptch_rt   (ptch_rt),
        .roll_rt   (roll_rt),
        .yaw_rt    (yaw_rt),
        .ax        (ax),
        .ay        (ay),
        .vld       (vld),
        .init_done (init_done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  b [10];
        logic [15:0] e [5];
    } vec_t;
    vec_t tv [5];

    logic [15:0] cfg_exp [4];
    string       fname [5];

    logic [79:0] outs;
    assign outs = {ptch_rt, roll_rt, yaw_rt, ax, ay};

    // ---------------- edge counter ----------------
    int edges = 0;
    initial forever begin
        @(posedge clk);
        edges++;
    end

    // ---------------- SPI responder ----------------
    logic [7:0]  q_resp [$];
    bit          m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [15:0] m_cmd  = '0;
    int          wrt_while_busy = 0;

    initial forever begin
        @(negedge clk);
        m_done = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (wrt) wrt_while_busy++;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                m_busy = 1'b0;
                if (m_cmd[7:0] == 8'h00 && q_resp.size() > 0)
                    m_resp = {8'h5A, q_resp.pop_front()};
                else
                    m_resp = 16'h5A00;
            end else begin
                m_cnt--;
            end
        end else if (wrt) begin
            m_busy = 1'b1;
            m_cnt  = LAT - 1;
            m_cmd  = cmd;
        end
    end

    // ---------------- monitor ----------------
    int          n_wrt = 0, n_done = 0, n_vld = 0;
    int          done_edge = 0, vld_lat_bad = 0, vld_wide = 0;
    logic        prev_vld = 1'b0;
    logic [15:0] cmd_log [$];
    int          wrt_edge [$];
    int          vld_edge [$];
    logic [79:0] out_log [$];

    initial forever begin
        @(negedge clk);
        #1;
        if (wrt) begin
            n_wrt++;
            cmd_log.push_back(cmd);
            wrt_edge.push_back(edges);
        end
        if (done) begin
            n_done++;
            done_edge = edges;
        end
        if (vld) begin
            n_vld++;
            vld_edge.push_back(edges);
            out_log.push_back(outs);
            if (edges != done_edge + 1) vld_lat_bad++;
            if (prev_vld) vld_wide++;
        end
        prev_vld = vld;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic logic [15:0] get_cmd(input int i);
        return (i >= 0 && i < cmd_log.size()) ? cmd_log[i] : 16'hDEAD;
    endfunction

    function automatic int get_wedge(input int i);
        return (i >= 0 && i < wrt_edge.size()) ? wrt_edge[i] : -1000;
    endfunction

    function automatic int get_vedge(input int i);
        return (i >= 0 && i < vld_edge.size()) ? vld_edge[i] : -1000;
    endfunction

    function automatic logic [79:0] pk(input int v);
        return {tv[v].e[0], tv[v].e[1], tv[v].e[2], tv[v].e[3], tv[v].e[4]};
    endfunction

    task automatic pulse_tdone(input logic [15:0] r);
        t_resp = r;
        t_done = 1'b1;
        step();
        t_done = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wrt"},       wrt,       0);
        chk({tag, "_cmd"},       cmd,       0);
        chk({tag, "_outs"},      outs,      0);
        chk({tag, "_vld"},       vld,       0);
        chk({tag, "_init_done"}, init_done, 0);
    endtask

    task automatic release_and_init(input string tag);
        int bw;
        bw    = n_wrt;
        edges = 0;
        rst_n = 1'b1;
        repeat (4) step();
        pulse_tdone(16'h00C3);
        chk({tag, "_no_early_wrt"}, 80'(n_wrt - bw), 0);
        for (int i = 0; i < 400 && !init_done; i++) step();
        chk({tag, "_init_done"}, init_done, 1);
        chk_rng({tag, "_first_wrt_edge"}, get_wedge(bw), 15, 17);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_cfg%0d", tag, k), get_cmd(bw + k), cfg_exp[k]);
        repeat (20) step();
        chk({tag, "_idle_no_wrt"}, 80'(n_wrt - bw), 4);
    endtask

    task automatic chk_reads(input string tag, input int base, input int n);
        logic [7:0] a;
        for (int k = 0; k < n; k++) begin
            a = 8'hA2 + 8'(k % 10);
            chk($sformatf("%s_rdcmd%0d", tag, k), get_cmd(base + k), {a, 8'h00});
        end
    endtask

    task automatic run_burst(input int v, input logic [79:0] prev);
        int bw, bv, e0;
        bit ok;
        for (int k = 0; k < 10; k++) q_resp.push_back(tv[v].b[k]);
        bw  = n_wrt;
        bv  = n_vld;
        INT = 1'b1;
        e0  = edges;
        for (int i = 0; i < 20 && n_wrt == bw; i++) step();
        INT = 1'b0;
        chk_rng($sformatf("b%0d_int_to_wrt", v), get_wedge(bw) - e0, 3, 3);
        ok = 1'b1;
        for (int i = 0; i < 400 && n_vld == bv; i++) begin
            if (outs !== prev) ok = 1'b0;
            step();
        end
        chk($sformatf("b%0d_atomic", v), ok, 1);
        chk($sformatf("b%0d_vld_count", v), 80'(n_vld - bv), 1);
        step();
        chk($sformatf("b%0d_vld_low", v), vld, 0);
        chk_reads($sformatf("b%0d", v), bw, 10);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int bw, bv, bd, k, gap;
        logic [79:0] o;

        cfg_exp = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
        fname   = '{"ptch_rt", "roll_rt", "yaw_rt", "ax", "ay"};

        tv[0].b = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hFF, 8'h7F, 8'h00, 8'h80};
        tv[0].e = '{16'h1234, 16'hABCD, 16'h0001, 16'h7FFF, 16'h8000};
        tv[1].b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        tv[1].e = '{16'h2211, 16'h4433, 16'h6655, 16'h8877, 16'hAA99};
        tv[2].b = '{8'h01, 8'h80, 8'h02, 8'h40, 8'h03, 8'h20, 8'h04, 8'h10, 8'h05, 8'h08};
        tv[2].e = '{16'h8001, 16'h4002, 16'h2003, 16'h1004, 16'h0805};
        tv[3].b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tv[3].e = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tv[4].b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0F, 8'hF0, 8'h5A, 8'hA5, 8'hC3, 8'h3C};
        tv[4].e = '{16'hADDE, 16'hEFBE, 16'hF00F, 16'hA55A, 16'h3CC3};

        INT   = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk_reset("reset");

        release_and_init("init");

        // Spurious done while idle in WAIT_INT.
        bw = n_wrt;
        bv = n_vld;
        pulse_tdone(16'h00FF);
        repeat (5) step();
        chk("spur_wait_int_wrt",  80'(n_wrt - bw), 0);
        chk("spur_wait_int_vld",  80'(n_vld - bv), 0);
        chk("spur_wait_int_outs", outs, 0);

        run_burst(0, 80'd0);
        run_burst(1, pk(0));

        // INT held high for three bursts, with INT toggled early in RD.
        for (int v = 2; v < 5; v++)
            for (int j = 0; j < 10; j++) q_resp.push_back(tv[v].b[j]);
        bw  = n_wrt;
        bv  = n_vld;
        INT = 1'b1;
        for (int i = 0; i < 1500 && n_vld < bv + 3; i++) begin
            k = n_wrt - bw;
            if (k >= 3 && k < 5) INT = ~INT;
            else if (k >= 30)    INT = 1'b0;
            else                 INT = 1'b1;
            step();
        end
        INT = 1'b0;
        chk("held_vld_count", 80'(n_vld - bv), 3);
        repeat (40) step();
        chk("held_total_wrt", 80'(n_wrt - bw), 30);
        chk("held_no_extra_vld", 80'(n_vld - bv), 3);
        chk_reads("held", bw, 30);
        for (int b = 1; b < 3; b++) begin
            gap = get_wedge(bw + 10 * b) - get_vedge(bv + b - 1);
            chk_rng($sformatf("held_restart_gap%0d", b), gap, 1, 2);
        end

        // Published samples against the vector table.
        for (int v = 0; v < 5; v++) begin
            o = (v < out_log.size()) ? out_log[v] : 80'h0;
            for (int f = 0; f < 5; f++)
                chk($sformatf("v%0d_%s", v, fname[f]), o[79 - 16 * f -: 16], tv[v].e[f]);
        end

        // Reset in the middle of a burst.
        for (int j = 0; j < 10; j++) q_resp.push_back(tv[0].b[j]);
        bd  = n_done;
        INT = 1'b1;
        for (int i = 0; i < 400 && n_done < bd + 5; i++) step();
        chk("midrst_reached_5th_done", 80'(n_done - bd), 5);
        step();
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        INT = 1'b0;
        q_resp.delete();
        repeat (2) step();
        bv = n_vld;
        release_and_init("rerun");
        chk("rerun_no_vld", 80'(n_vld - bv), 0);

        chk("wrt_while_busy", 80'(wrt_while_busy), 0);
        chk("vld_latency_bad", 80'(vld_lat_bad), 0);
        chk("vld_wide", 80'(vld_wide), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
